pt_checker: RTL and testbench
=============================

Name: pt_checker

Overview:
- Reads a length-prefixed plaintext buffer: byte 0 holds the length n, bytes 1..n hold the message.
- Decides whether every message byte is printable ASCII.
- Consumes the plaintext memory that the RC4 PRGA writes, and is used by the key-search controller to accept or reject a candidate key.
- Runs as a single FSM with an en/rdy handshake and early exit on the first bad byte.

Parameters:
LO, 8'h20, lowest accepted byte value (inclusive)
HI, 8'h7E, highest accepted byte value (inclusive)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  start request; sampled only while rdy=1
rdy  output  1  1 = idle/done and able to accept en
valid  output  1  result: 1 = all n bytes lie in [LO,HI]; held until the next start
bad_index  output  8  address of the first rejected byte; 0 when valid=1; held until the next start
msg_len  output  8  length byte read from address 0; held until the next start
pt_addr  output  8  plaintext memory read address (registered)
pt_rddata  input  8  plaintext memory read data, 1-cycle synchronous read latency

Behaviour:
- Plaintext memory is read-only for this block; no write port.
- Reset (async, any state): state=IDLE, rdy=1, valid=0, bad_index=0, msg_len=0, pt_addr=0, k=1.
- States: IDLE, ADDR_LEN, WAIT_LEN, LATCH_LEN, ADDR_CH, WAIT_CH, CHECK_CH, DONE.
- IDLE / DONE: rdy=1, pt_addr=0.
  - en=1 at the edge -> ADDR_LEN.
  - That same edge clears rdy, valid, bad_index and msg_len.
  - DONE otherwise holds all results.
- ADDR_LEN: pt_addr=0 -> WAIT_LEN -> LATCH_LEN.
- LATCH_LEN: capture msg_len=pt_rddata.
  - len=0 -> DONE with valid=1, bad_index=0.
  - Otherwise k=1 -> ADDR_CH.
- ADDR_CH: pt_addr=k -> WAIT_CH -> CHECK_CH.
- CHECK_CH: test c=pt_rddata with the unsigned inclusive compare LO<=c<=HI.
  - Fail -> DONE, valid=0, bad_index=k (early exit; remaining bytes not read).
  - Pass and k==msg_len -> DONE, valid=1, bad_index=0.
  - Pass and k!=msg_len -> k=k+1, go to ADDR_CH.
- k is 8 bits. The compare happens before the increment, so len=255 ends at k=255 with no wrap.
- Latency, counting the start edge as edge 0:
  - rdy returns to 1 at edge 3n+3 when all bytes pass.
  - rdy returns to 1 at edge 3m+3 when byte m is the first failure.
  - len=0 gives edge 3.
- rdy is low for every cycle between the start edge and that completion edge.
- en while rdy=0 is ignored. No abort; only rst_n stops an operation.
- en held high through DONE immediately restarts a new check; results are cleared at that edge.
- pt_addr is 0 in every state except ADDR_LEN (0) and ADDR_CH (k). After ADDR_CH it stays at k through WAIT_CH.
- Reset asserted mid-operation: outputs take their reset values immediately. No partial result remains visible after deassertion.

Test Plan:
- Memory {0x00} -> en pulse -> rdy high at edge 3, valid=1, msg_len=0, bad_index=0; addresses 1+ never driven.
- Memory {0x03,'H','i','!'} -> rdy at edge 12, valid=1, msg_len=3, bad_index=0; pt_addr sequence 0,1,2,3.
- Memory {0x05,'a','b',0x0A,'c','d'} -> rdy at edge 12, valid=0, bad_index=3; address 4 never presented.
- Boundaries:
  - {0x02,0x20,0x7E} -> valid=1.
  - {0x01,0x1F} -> valid=0, bad_index=1.
  - {0x01,0x7F} -> valid=0, bad_index=1.
  - {0x01,0x80} -> valid=0, bad_index=1 (unsigned compare).
- len=255, all 0x41 -> rdy at edge 768, valid=1, k never wraps.
- Handshake and reset:
  - en held high for the entire run -> no restart while busy; a new run starts on the edge leaving DONE.
  - rst_n pulsed during CHECK_CH -> rdy=1, valid=0, state IDLE.
  - A following en completes normally.

Source files
------------

// File: rtl/pt_checker_if.sv
// Handshake and plaintext-memory read bus between the key-search side and pt_checker.
interface pt_checker_if;
  logic       en;
  logic       rdy;
  logic       valid;
  logic [7:0] bad_index;
  logic [7:0] msg_len;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;

  modport master (
    output en,
    output pt_rddata,
    input  rdy,
    input  valid,
    input  bad_index,
    input  msg_len,
    input  pt_addr
  );

  modport slave (
    input  en,
    input  pt_rddata,
    output rdy,
    output valid,
    output bad_index,
    output msg_len,
    output pt_addr
  );
endinterface

// File: rtl/pt_checker.sv
// Walks a length-prefixed plaintext buffer and reports whether every byte is printable,
// stopping at the first byte outside [LO, HI].
module pt_checker #(
  parameter logic [7:0] LO = 8'h20,
  parameter logic [7:0] HI = 8'h7E
) (
  input  logic        clk,
  input  logic        rst_n,
  pt_checker_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrLen,
    StWaitLen,
    StLatchLen,
    StAddrCh,
    StWaitCh,
    StCheckCh,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] k_q, k_d;
  logic       valid_q, valid_d;
  logic [7:0] bad_index_q, bad_index_d;
  logic [7:0] msg_len_q, msg_len_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic       in_range;

  assign in_range = (bus.pt_rddata >= LO) && (bus.pt_rddata <= HI);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    valid_d     = valid_q;
    bad_index_d = bad_index_q;
    msg_len_d   = msg_len_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.en) begin
          state_d     = StAddrLen;
          valid_d     = 1'b0;
          bad_index_d = 8'd0;
          msg_len_d   = 8'd0;
        end
      end
      StAddrLen: state_d = StWaitLen;
      StWaitLen: state_d = StLatchLen;
      StLatchLen: begin
        msg_len_d = bus.pt_rddata;
        if (bus.pt_rddata == 8'd0) begin
          state_d     = StDone;
          valid_d     = 1'b1;
          bad_index_d = 8'd0;
        end else begin
          k_d     = 8'd1;
          state_d = StAddrCh;
        end
      end
      StAddrCh: state_d = StWaitCh;
      StWaitCh: state_d = StCheckCh;
      StCheckCh: begin
        // Compare against the length before incrementing so len=255 never wraps k.
        if (!in_range) begin
          state_d     = StDone;
          valid_d     = 1'b0;
          bad_index_d = k_q;
        end else if (k_q == msg_len_q) begin
          state_d     = StDone;
          valid_d     = 1'b1;
          bad_index_d = 8'd0;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = StAddrCh;
        end
      end
      default: state_d = StIdle;
    endcase

    // Address is held at k across the read latency cycle, zero elsewhere.
    pt_addr_d = ((state_d == StAddrCh) || (state_d == StWaitCh)) ? k_d : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= 8'd1;
      valid_q     <= 1'b0;
      bad_index_q <= 8'd0;
      msg_len_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      bad_index_q <= bad_index_d;
      msg_len_q   <= msg_len_d;
      pt_addr_q   <= pt_addr_d;
    end
  end

  assign bus.rdy       = (state_q == StIdle) || (state_q == StDone);
  assign bus.valid     = valid_q;
  assign bus.bad_index = bad_index_q;
  assign bus.msg_len   = msg_len_q;
  assign bus.pt_addr   = pt_addr_q;

endmodule

// File: tb/tb_pt_checker.sv
// Directed bench for pt_checker: table of small buffers plus hand-written
// sequences for the long message, held-en restart and mid-run reset.
module tb_pt_checker;

  logic clk;
  logic rst_n;
  logic [7:0] mem [256];

  int total;
  int bad;

  pt_checker_if bus ();

  pt_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous read memory.
  always @(posedge clk) bus.pt_rddata <= mem[bus.pt_addr];

  typedef struct {
    string      name;
    logic [7:0] b [6];
    logic       exp_valid;
    logic [7:0] exp_bad;
    logic [7:0] exp_len;
    int         exp_edges;
    int         exp_maxa;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Start on edge 0, then count edges until rdy is seen high again.
  task automatic run(output int edges, output int maxa, output int low0);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    low0 = (bus.rdy == 1'b0) ? 1 : 0;
    edges = 0;
    maxa = int'(bus.pt_addr);
    while (edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
      if (int'(bus.pt_addr) > maxa) maxa = int'(bus.pt_addr);
      if (bus.rdy) break;
    end
  endtask

  initial begin
    int edges, maxa, low0;
    total = 0;
    bad = 0;
    bus.en = 1'b0;
    rst_n = 1'b0;
    clear_mem();

    vecs[0] = '{"len0",    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd0, 3, 0};
    vecs[1] = '{"hi",      '{8'h03, 8'h48, 8'h69, 8'h21, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd3, 12, 3};
    vecs[2] = '{"newline", '{8'h05, 8'h61, 8'h62, 8'h0A, 8'h63, 8'h64}, 1'b0, 8'd3, 8'd5, 12, 3};
    vecs[3] = '{"edges",   '{8'h02, 8'h20, 8'h7E, 8'h00, 8'h00, 8'h00}, 1'b1, 8'd0, 8'd2, 9, 2};
    vecs[4] = '{"x1f",     '{8'h01, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 8'd1, 8'd1, 6, 1};
    vecs[5] = '{"x7f",     '{8'h01, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 8'd1, 8'd1, 6, 1};
    vecs[6] = '{"x80",     '{8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 8'd1, 8'd1, 6, 1};

    #23;
    chk("reset_rdy", int'(bus.rdy), 1);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_bad", int'(bus.bad_index), 0);
    chk("reset_len", int'(bus.msg_len), 0);
    chk("reset_addr", int'(bus.pt_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      clear_mem();
      for (int j = 0; j < 6; j++) mem[j] = vecs[i].b[j];
      run(edges, maxa, low0);
      chk({vecs[i].name, "_busy"}, low0, 1);
      chk({vecs[i].name, "_edges"}, edges, vecs[i].exp_edges);
      chk({vecs[i].name, "_valid"}, int'(bus.valid), int'(vecs[i].exp_valid));
      chk({vecs[i].name, "_bad"}, int'(bus.bad_index), int'(vecs[i].exp_bad));
      chk({vecs[i].name, "_len"}, int'(bus.msg_len), int'(vecs[i].exp_len));
      chk({vecs[i].name, "_maxaddr"}, maxa, vecs[i].exp_maxa);
    end

    // Results hold in DONE while en stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_bad", int'(bus.bad_index), 1);
    chk("hold_rdy", int'(bus.rdy), 1);

    // Longest message: k must stop at 255.
    clear_mem();
    mem[0] = 8'hFF;
    for (int j = 1; j < 256; j++) mem[j] = 8'h41;
    run(edges, maxa, low0);
    chk("len255_edges", edges, 768);
    chk("len255_valid", int'(bus.valid), 1);
    chk("len255_len", int'(bus.msg_len), 255);
    chk("len255_maxaddr", maxa, 255);

    // en held high: busy for edges 1..5, done at 6, restart on edge 7.
    clear_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h41;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    edges = 0;
    low0 = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) begin
        edges = e;
        break;
      end
    end
    chk("held_edges", edges, 6);
    chk("held_valid", int'(bus.valid), 1);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    chk("held_restart_rdy", int'(bus.rdy), 0);
    chk("held_restart_valid", int'(bus.valid), 0);
    chk("held_restart_len", int'(bus.msg_len), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("held_second_rdy", int'(bus.rdy), 1);
    chk("held_second_valid", int'(bus.valid), 1);

    // Reset while in CHECK_CH (after edge 5 of a 3-byte run).
    clear_mem();
    mem[0] = 8'h03;
    mem[1] = 8'h41;
    mem[2] = 8'h42;
    mem[3] = 8'h43;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", int'(bus.rdy), 0);
    chk("mid_len_seen", int'(bus.msg_len), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", int'(bus.rdy), 1);
    chk("mid_rst_valid", int'(bus.valid), 0);
    chk("mid_rst_len", int'(bus.msg_len), 0);
    chk("mid_rst_addr", int'(bus.pt_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(bus.rdy), 1);
    chk("post_rst_valid", int'(bus.valid), 0);
    run(edges, maxa, low0);
    chk("post_rst_edges", edges, 12);
    chk("post_rst_valid_done", int'(bus.valid), 1);
    chk("post_rst_len", int'(bus.msg_len), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
